// File: rtl/mat_pkg.sv
// Shared definitions for the matrix datapath: loader FSM encoding and size helpers.
package mat_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    START  = 2'd2,
    WAIT   = 2'd3
  } state_e;

  // Number of elements in one n x n matrix.
  function automatic int mat_elems(input int dim);
    return dim * dim;
  endfunction

  // Element counter width: enough to index one matrix, never less than one bit.
  function automatic int mat_cnt_w(input int dim);
    int w;
    w = $clog2(dim * dim);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mat_stream_loader_if.sv
// Element stream into the loader: one matrix element per valid/ready beat.
interface mat_stream_loader_if #(
  parameter int width = 32
) ();

  logic [width-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/mat_stream_loader.sv
// Assembles a streamed frame (A then B, row-major) into flattened a/b buses,
// fires a one-cycle start to mat_mul and holds a/b until mat_mul signals done.
module mat_stream_loader
  import mat_pkg::*;
#(
  parameter int width = 32,
  parameter int n     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  mat_stream_loader_if.slave     s,
  output logic [n*n*width-1:0]   a,
  output logic [n*n*width-1:0]   b,
  output logic                   start,
  input  logic                   mm_done,
  output logic                   busy,
  output logic                   frame_err
);

  localparam int ELEMS = mat_elems(n);
  localparam int CW    = mat_cnt_w(n);
  localparam logic [CW-1:0] LAST_IDX = CW'(ELEMS - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [n*n*width-1:0]   a_q, a_d;
  logic [n*n*width-1:0]   b_q, b_d;
  logic                   busy_q, busy_d;
  logic                   frame_err_q, frame_err_d;
  logic                   done_q, done_d;
  logic                   accept;
  logic                   done_rise;
  logic                   last_beat;

  // Stream is only open while loading, and closed outright during reset.
  assign s.in_ready = ~rst & ((state_q == LOAD_A) | (state_q == LOAD_B));
  assign accept     = s.in_valid & s.in_ready;

  assign a         = a_q;
  assign b         = b_q;
  assign start     = (state_q == START);
  assign frame_err = frame_err_q;
  // busy falls in the very cycle the mm_done rising edge is seen.
  assign busy      = busy_q & ~done_rise;

  // Next-state, element write decode, framing check and mm_done edge detect.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    frame_err_d = 1'b0;
    done_d      = mm_done;
    done_rise   = 1'b0;
    last_beat   = (count_q == LAST_IDX);

    case (state_q)
      LOAD_A: begin
        if (accept) begin
          a_d[int'(count_q)*width +: width] = s.in_data;
          busy_d = 1'b1;
          // No element of A may carry in_last.
          if (s.in_last) begin
            frame_err_d = 1'b1;
            count_d     = '0;
            busy_d      = 1'b0;
          end else if (last_beat) begin
            count_d = '0;
            state_d = LOAD_B;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          b_d[int'(count_q)*width +: width] = s.in_data;
          busy_d = 1'b1;
          // in_last must appear exactly on the final element of B.
          if (s.in_last != last_beat) begin
            frame_err_d = 1'b1;
            count_d     = '0;
            busy_d      = 1'b0;
            state_d     = LOAD_A;
          end else if (last_beat) begin
            count_d = '0;
            state_d = START;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A level already high on entry has done_q set, so it is not an edge.
        done_rise = mm_done & ~done_q;
        if (done_rise) begin
          state_d = LOAD_A;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = LOAD_A;
        count_d = '0;
      end
    endcase
  end

  // State and data registers; reset returns everything to the idle, cleared frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD_A;
      count_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_mat_stream_loader.sv
// Randomized bench for mat_stream_loader with a frame-level behavioural model.
module tb_mat_stream_loader;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int E  = N * N;
  localparam int BW = N * N * W;

  logic          clk;
  logic          rst;
  logic          mm_done;
  logic [BW-1:0] a;
  logic [BW-1:0] b;
  logic          start;
  logic          busy;
  logic          frame_err;

  mat_stream_loader_if #(.width(W)) sif ();

  mat_stream_loader #(.width(W), .n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (sif.slave),
    .a         (a),
    .b         (b),
    .start     (start),
    .mm_done   (mm_done),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int n_ferr   = 0;

  logic drv_rst = 1'b0;
  logic drv_mm  = 1'b0;
  logic last_start;
  logic last_busy;

  // Behavioural model: frame beat index, expected matrices and run phase.
  int            m_beat;
  logic [BW-1:0] m_a, m_b;
  logic          m_busy, m_ferr, m_start, m_wait, m_done_prev;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_beat = 0; m_a = '0; m_b = '0;
    m_busy = 0; m_ferr = 0; m_start = 0; m_wait = 0; m_done_prev = 0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic tick(input logic v, input logic [W-1:0] d, input logic l, output logic acc);
    logic rdy, rise, exp_last;
    logic nf, ns;
    @(negedge clk);
    rst = drv_rst; mm_done = drv_mm;
    sif.in_valid = v; sif.in_data = d; sif.in_last = l;
    #1;
    rdy  = !drv_rst && !m_start && !m_wait;
    rise = m_wait && drv_mm && !m_done_prev;
    check("in_ready", BW'(sif.in_ready), BW'(rdy));
    check("start", BW'(start), BW'(m_start));
    check("busy", BW'(busy), BW'(m_busy && !rise));
    check("frame_err", BW'(frame_err), BW'(m_ferr));
    check("a", a, m_a);
    check("b", b, m_b);
    last_start = start;
    last_busy  = busy;
    if (start === 1'b1) n_starts++;
    if (frame_err === 1'b1) n_ferr++;
    acc = v && rdy;
    if (drv_rst) begin
      model_reset();
    end else begin
      nf = 0; ns = 0;
      if (m_start) begin
        m_wait = 1;
      end else if (m_wait) begin
        if (rise) begin m_wait = 0; m_busy = 0; end
      end else if (acc) begin
        if (m_beat < E) m_a[m_beat*W +: W] = d;
        else            m_b[(m_beat-E)*W +: W] = d;
        m_busy   = 1;
        exp_last = (m_beat == 2*E-1);
        if (l != exp_last) begin
          nf = 1; m_beat = 0; m_busy = 0;
        end else if (exp_last) begin
          ns = 1; m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      m_ferr = nf; m_start = ns; m_done_prev = drv_mm;
    end
    @(posedge clk);
  endtask

  // Offer nbeats elements, optionally with random idle cycles between them.
  task automatic send_frame(input logic [W-1:0] vals [2*E], input int nbeats,
                            input int last_pos, input bit gaps);
    logic acc;
    int   guard;
    for (int k = 0; k < nbeats; k++) begin
      acc = 0; guard = 0;
      while (!acc && guard < 200) begin
        tick(gaps ? 1'($urandom_range(0, 1)) : 1'b1, vals[k], (k == last_pos), acc);
        guard++;
      end
      if (!acc) begin
        n_checks++; n_fail++;
        $display("FAIL beat_accept: beat %0d not accepted within 200 cycles", k);
      end
    end
  endtask

  // Let the run sit in WAIT with junk offered, then pulse mm_done.
  task automatic finish_run(input int idle);
    logic acc;
    for (int i = 0; i < idle; i++) tick(1'b1, W'($urandom), 1'b0, acc);
    drv_mm = 1; tick(1'b0, '0, 1'b0, acc);
    drv_mm = 0; tick(1'b0, '0, 1'b0, acc);
  endtask

  logic [W-1:0] fr  [2*E];
  logic [W-1:0] rnd [2*E];
  logic         dummy;
  logic [W-1:0] csum;

  initial begin
    sif.in_valid = 0; sif.in_data = '0; sif.in_last = 0;
    mm_done = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    model_reset();

    // Test 1: first cycle after release.
    tick(1'b0, '0, 1'b0, dummy);
    check("t1_a_zero", a, '0);
    check("t1_ready", BW'(sif.in_ready), BW'(1));

    // Test 2: 1..9 then 9..1, back to back.
    for (int k = 0; k < E; k++) begin fr[k] = W'(k + 1); fr[E+k] = W'(E - k); end
    send_frame(fr, 2*E, 2*E-1, 1'b0);
    check("t2_start_on_beat18", BW'(last_start), BW'(0));
    tick(1'b0, '0, 1'b0, dummy);
    check("t2_start_after_beat18", BW'(last_start), BW'(1));
    check("t2_a0", BW'(a[31:0]), BW'(1));
    check("t2_a8", BW'(a[287:256]), BW'(9));
    check("t2_b0", BW'(b[31:0]), BW'(9));
    csum = '0;
    for (int k = 0; k < N; k++) csum += a[k*W +: W] * b[(k*N)*W +: W];
    check("t2_c00", BW'(csum), BW'(30));
    finish_run(3);

    // Test 3: same frame with random valid gaps.
    send_frame(fr, 2*E, 2*E-1, 1'b1);
    tick(1'b0, '0, 1'b0, dummy);
    check("t3_start", BW'(last_start), BW'(1));
    finish_run(6);
    check("t3_b8", BW'(b[287:256]), BW'(1));

    // Test 4: in_last on beat 5, then a clean random frame.
    for (int k = 0; k < 2*E; k++) rnd[k] = W'($urandom);
    send_frame(rnd, 5, 4, 1'b1);
    tick(1'b0, '0, 1'b0, dummy);
    check("t4_busy_after_err", BW'(last_busy), BW'(0));
    for (int k = 0; k < 2*E; k++) rnd[k] = W'($urandom);
    send_frame(rnd, 2*E, 2*E-1, 1'b1);
    finish_run(2);

    // Test 5: missing in_last, then mm_done held high across two frames.
    for (int k = 0; k < 2*E; k++) rnd[k] = W'($urandom);
    send_frame(rnd, 2*E, -1, 1'b0);
    for (int k = 0; k < 2*E; k++) rnd[k] = W'($urandom);
    send_frame(rnd, 2*E, 2*E-1, 1'b1);
    repeat (3) tick(1'b0, '0, 1'b0, dummy);
    drv_mm = 1;
    repeat (2) tick(1'b0, '0, 1'b0, dummy);
    for (int k = 0; k < 2*E; k++) rnd[k] = W'($urandom);
    send_frame(rnd, 2*E, 2*E-1, 1'b1);
    repeat (5) tick(1'b1, W'($urandom), 1'b0, dummy);
    check("t5_still_waiting", BW'(last_busy), BW'(1));
    drv_mm = 0; tick(1'b0, '0, 1'b0, dummy);
    drv_mm = 1; tick(1'b0, '0, 1'b0, dummy);
    drv_mm = 0; tick(1'b0, '0, 1'b0, dummy);

    // Test 6: reset after 7 beats, then a full frame.
    for (int k = 0; k < 2*E; k++) rnd[k] = W'($urandom);
    send_frame(rnd, 7, -1, 1'b0);
    drv_rst = 1; tick(1'b1, W'($urandom), 1'b0, dummy);
    drv_rst = 0; tick(1'b0, '0, 1'b0, dummy);
    check("t6_a_cleared", a, '0);
    for (int k = 0; k < 2*E; k++) rnd[k] = W'($urandom);
    send_frame(rnd, 2*E, 2*E-1, 1'b1);
    finish_run(2);

    check("total_starts", BW'(n_starts), BW'(6));
    check("total_frame_err", BW'(n_ferr), BW'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
